// File: rtl/lockout_timer.sv
// Brute-force guard: counts consecutive failed password attempts and, once the
// limit is hit, holds the lock asleep for a fixed number of seconds.
module lockout_timer #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int MAX_FAILS = 3,
    parameter int LOCKOUT_S = 10
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       invalid_pw,
    input  logic       correct_pw,
    output logic       sleep,
    output logic       end_sleep,
    output logic [3:0] attempts_left,
    output logic [3:0] secs_left
);

    localparam int              PW        = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0]   PRESC_MAX = PW'(CLK_HZ - 1);
    localparam logic [3:0]      FAILS_MAX = 4'(MAX_FAILS);
    localparam logic [3:0]      SECS_INIT = 4'(LOCKOUT_S);

    typedef enum logic [1:0] {
        ARMED  = 2'b00,
        LOCKED = 2'b01
    } state_t;

    state_t        state, state_nxt;
    logic [3:0]    fail_cnt, fail_nxt;
    logic [3:0]    sec_cnt, sec_nxt;
    logic [PW-1:0] presc, presc_nxt;
    logic          invalid_q, correct_q;
    logic          invalid_edge, correct_edge;
    logic          end_sleep_nxt;

    assign invalid_edge = invalid_pw & ~invalid_q;
    assign correct_edge = correct_pw & ~correct_q;

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        state_nxt = state;
        fail_nxt  = fail_cnt;
        sec_nxt   = sec_cnt;
        presc_nxt = presc;

        case (state)
            ARMED: begin
                presc_nxt = '0;
                sec_nxt   = 4'd0;
                if (correct_edge) begin
                    fail_nxt = 4'd0;
                end else if (invalid_edge) begin
                    if (fail_cnt == FAILS_MAX - 4'd1) begin
                        state_nxt = LOCKED;
                        fail_nxt  = FAILS_MAX;
                        sec_nxt   = SECS_INIT;
                    end else begin
                        fail_nxt = fail_cnt + 4'd1;
                    end
                end
            end

            LOCKED: begin
                if (presc == PRESC_MAX) begin
                    presc_nxt = '0;
                    // A zero count can only come from corruption; release too.
                    if (sec_cnt <= 4'd1) begin
                        state_nxt = ARMED;
                        fail_nxt  = 4'd0;
                        sec_nxt   = 4'd0;
                    end else begin
                        sec_nxt = sec_cnt - 4'd1;
                    end
                end else begin
                    presc_nxt = presc + PW'(1);
                end
            end

            default: begin
                state_nxt = ARMED;
                fail_nxt  = 4'd0;
                sec_nxt   = 4'd0;
                presc_nxt = '0;
            end
        endcase
    end

    // end_sleep is registered, so it is raised for the cycle that will be the
    // final lockout cycle, looking at the values about to be loaded.
    assign end_sleep_nxt = (state_nxt == LOCKED) && (presc_nxt == PRESC_MAX) &&
                           (sec_nxt == 4'd1);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ARMED;
            fail_cnt      <= 4'd0;
            sec_cnt       <= 4'd0;
            presc         <= '0;
            invalid_q     <= 1'b0;
            correct_q     <= 1'b0;
            sleep         <= 1'b0;
            end_sleep     <= 1'b0;
            attempts_left <= FAILS_MAX;
            secs_left     <= 4'd0;
        end else begin
            state         <= state_nxt;
            fail_cnt      <= fail_nxt;
            sec_cnt       <= sec_nxt;
            presc         <= presc_nxt;
            invalid_q     <= invalid_pw;
            correct_q     <= correct_pw;
            sleep         <= (state_nxt == LOCKED);
            end_sleep     <= end_sleep_nxt;
            attempts_left <= FAILS_MAX - fail_nxt;
            secs_left     <= sec_nxt;
        end
    end

endmodule

// File: tb/tb_lockout_timer.sv
// Self-checking bench for lockout_timer: directed scenarios plus random
// stimulus, compared against a cycle-count model of the lockout rules.
module tb_lockout_timer;

    localparam int CLK_HZ    = 4;
    localparam int MAX_FAILS = 3;
    localparam int LOCKOUT_S = 2;

    logic       clk        = 1'b0;
    logic       reset_n    = 1'b0;
    logic       invalid_pw = 1'b0;
    logic       correct_pw = 1'b0;
    logic       sleep;
    logic       end_sleep;
    logic [3:0] attempts_left;
    logic [3:0] secs_left;

    int checks = 0;
    int errors = 0;

    // Reference model: failures so far and cycles of lockout still to run.
    int   m_fails    = 0;
    int   m_rem      = 0;
    logic m_prev_inv = 1'b0;
    logic m_prev_cor = 1'b0;

    always #5 clk = ~clk;

    lockout_timer #(
        .CLK_HZ   (CLK_HZ),
        .MAX_FAILS(MAX_FAILS),
        .LOCKOUT_S(LOCKOUT_S)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .invalid_pw   (invalid_pw),
        .correct_pw   (correct_pw),
        .sleep        (sleep),
        .end_sleep    (end_sleep),
        .attempts_left(attempts_left),
        .secs_left    (secs_left)
    );

    function automatic void model_reset();
        m_fails    = 0;
        m_rem      = 0;
        m_prev_inv = 1'b0;
        m_prev_cor = 1'b0;
    endfunction

    function automatic void model_clock(input logic inv, input logic cor);
        logic ie;
        logic ce;
        ie = inv && !m_prev_inv;
        ce = cor && !m_prev_cor;
        m_prev_inv = inv;
        m_prev_cor = cor;
        if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) m_fails = 0;
        end else if (ce) begin
            m_fails = 0;
        end else if (ie) begin
            m_fails++;
            if (m_fails == MAX_FAILS) m_rem = LOCKOUT_S * CLK_HZ;
        end
    endfunction

    // {sleep, end_sleep, attempts_left, secs_left} as the rules dictate.
    function automatic logic [9:0] model_out();
        logic [3:0] secs;
        logic [3:0] att;
        secs = 4'((m_rem + CLK_HZ - 1) / CLK_HZ);
        att  = 4'(MAX_FAILS - m_fails);
        return {(m_rem > 0), (m_rem == 1), att, secs};
    endfunction

    task automatic tick(input logic inv, input logic cor);
        @(negedge clk);
        invalid_pw = inv;
        correct_pw = cor;
        @(posedge clk);
        model_clock(inv, cor);
        #1;
    endtask

    task automatic do_reset();
        invalid_pw = 1'b0;
        correct_pw = 1'b0;
        reset_n    = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({sleep, end_sleep, attempts_left, secs_left} !== {1'b0, 1'b0, 4'd3, 4'd0}) begin
            errors++;
            $display("FAIL reset_values: got %b expected %b",
                     {sleep, end_sleep, attempts_left, secs_left}, {1'b0, 1'b0, 4'd3, 4'd0});
        end
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, 1'b0);
            checks++;
            if ({sleep, end_sleep, attempts_left, secs_left} !== {1'b0, 1'b0, 4'd3, 4'd0}) begin
                errors++;
                $display("FAIL idle[%0d]: got %b expected %b", i,
                         {sleep, end_sleep, attempts_left, secs_left}, {1'b0, 1'b0, 4'd3, 4'd0});
            end
        end
    endtask

    task automatic test_count_clear();
        logic       inv_s [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic       cor_s [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [3:0] exp_a [6] = '{4'd2, 4'd2, 4'd1, 4'd1, 4'd3, 4'd3};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            tick(inv_s[i], cor_s[i]);
            checks++;
            if (attempts_left !== exp_a[i] || sleep !== 1'b0) begin
                errors++;
                $display("FAIL count_clear[%0d]: got attempts=%0d sleep=%b expected attempts=%0d sleep=0",
                         i, attempts_left, sleep, exp_a[i]);
            end
        end
    endtask

    task automatic test_lockout();
        int sleep_cycles = 0;
        int end_cycles   = 0;
        int end_at       = -1;
        do_reset();
        tick(1'b1, 1'b0); tick(1'b0, 1'b0);
        tick(1'b1, 1'b0); tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        for (int i = 1; i <= 12; i++) begin
            if (i > 1) tick(1'b0, 1'b0);
            checks++;
            if ({sleep, end_sleep, attempts_left, secs_left} !== model_out()) begin
                errors++;
                $display("FAIL lockout[%0d]: got %b expected %b", i,
                         {sleep, end_sleep, attempts_left, secs_left}, model_out());
            end
            if (sleep) sleep_cycles++;
            if (end_sleep) begin
                end_cycles++;
                end_at = i;
            end
        end
        checks++;
        if (sleep_cycles !== 8 || end_cycles !== 1 || end_at !== 8) begin
            errors++;
            $display("FAIL lockout_len: got sleep=%0d pulses=%0d at=%0d expected 8 1 8",
                     sleep_cycles, end_cycles, end_at);
        end
        checks++;
        if (attempts_left !== 4'd3 || sleep !== 1'b0) begin
            errors++;
            $display("FAIL lockout_after: got attempts=%0d sleep=%b expected 3 0",
                     attempts_left, sleep);
        end
    endtask

    task automatic test_held_and_ignored();
        int   sleep_cycles = 0;
        logic inv;
        do_reset();
        repeat (10) tick(1'b1, 1'b0);
        checks++;
        if (attempts_left !== 4'd2) begin
            errors++;
            $display("FAIL held_once: got attempts=%0d expected 2", attempts_left);
        end
        tick(1'b0, 1'b0); tick(1'b1, 1'b0);
        tick(1'b0, 1'b0); tick(1'b1, 1'b0);
        if (sleep) sleep_cycles++;
        for (int i = 0; i < 16; i++) begin
            // Random presses while locked; the final locked cycle rises invalid.
            inv = (m_rem > 1) ? 1'($urandom_range(0, 1)) : (m_rem == 1);
            tick(inv, (m_rem > 1) ? 1'($urandom_range(0, 1)) : 1'b0);
            checks++;
            if ({sleep, end_sleep, attempts_left, secs_left} !== model_out()) begin
                errors++;
                $display("FAIL ignored[%0d]: got %b expected %b", i,
                         {sleep, end_sleep, attempts_left, secs_left}, model_out());
            end
            if (sleep) sleep_cycles++;
        end
        checks++;
        if (sleep_cycles !== 8 || attempts_left !== 4'd3) begin
            errors++;
            $display("FAIL ignored_len: got sleep=%0d attempts=%0d expected 8 3",
                     sleep_cycles, attempts_left);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        tick(1'b1, 1'b0); tick(1'b0, 1'b0);
        tick(1'b1, 1'b0); tick(1'b0, 1'b0);
        tick(1'b1, 1'b1);
        checks++;
        if (attempts_left !== 4'd3 || sleep !== 1'b0) begin
            errors++;
            $display("FAIL simultaneous: got attempts=%0d sleep=%b expected 3 0",
                     attempts_left, sleep);
        end
        tick(1'b0, 1'b0);
        checks++;
        if ({sleep, end_sleep, attempts_left, secs_left} !== model_out()) begin
            errors++;
            $display("FAIL simultaneous_after: got %b expected %b",
                     {sleep, end_sleep, attempts_left, secs_left}, model_out());
        end
    endtask

    task automatic test_reset_mid_lockout();
        int pulses = 0;
        do_reset();
        tick(1'b1, 1'b0); tick(1'b0, 1'b0);
        tick(1'b1, 1'b0); tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        repeat (4) tick(1'b0, 1'b0);
        checks++;
        if (sleep !== 1'b1 || secs_left !== 4'd1) begin
            errors++;
            $display("FAIL mid_lock_state: got sleep=%b secs=%0d expected 1 1", sleep, secs_left);
        end
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({sleep, end_sleep, attempts_left, secs_left} !== {1'b0, 1'b0, 4'd3, 4'd0}) begin
            errors++;
            $display("FAIL async_reset: got %b expected %b",
                     {sleep, end_sleep, attempts_left, secs_left}, {1'b0, 1'b0, 4'd3, 4'd0});
        end
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 1'b0);
            if (end_sleep) pulses++;
        end
        checks++;
        if (pulses !== 0 || attempts_left !== 4'd3 || sleep !== 1'b0) begin
            errors++;
            $display("FAIL after_reset: got pulses=%0d attempts=%0d sleep=%b expected 0 3 0",
                     pulses, attempts_left, sleep);
        end
    endtask

    task automatic test_random();
        logic inv;
        logic cor;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            inv = ($urandom_range(0, 2) == 0);
            cor = ($urandom_range(0, 9) == 0);
            tick(inv, cor);
            checks++;
            if ({sleep, end_sleep, attempts_left, secs_left} !== model_out()) begin
                errors++;
                $display("FAIL random[%0d]: got %b expected %b", i,
                         {sleep, end_sleep, attempts_left, secs_left}, model_out());
            end
        end
    endtask

    initial begin
        test_reset();
        test_count_clear();
        test_lockout();
        test_held_and_ignored();
        test_simultaneous();
        test_reset_mid_lockout();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
